// File: rtl/icc_monitor_seq.sv
// Multi-rail supply current monitor.
// Round-robins the analog mux over NUM_CH rails, averages 2**AVG_LOG2 soft-ADC
// samples per rail, and scales each average to a saturated 0..99 mA value.
// Results are held per channel as two BCD digits and drive per-rail
// over-current alarms with hysteresis plus a one-cycle standby request pulse.
module icc_monitor_seq #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 8,
    parameter int AVG_LOG2   = 2,
    parameter int SETTLE     = 1,
    parameter int INVERT     = 1,
    parameter int SHIFT_A    = 3,
    parameter int SHIFT_B    = 4,
    parameter int OFFSET     = 1,
    parameter int ALARM_THR  = 40,
    parameter int ALARM_HYST = 5,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rstn,
    input  logic              sample_rdy,
    input  logic [DATA_W-1:0] adc_data,
    output logic [CH_W-1:0]   mux_sel,
    input  logic [CH_W-1:0]   disp_ch,
    output logic              disp_valid,
    output logic [3:0]        disp_tens,
    output logic [3:0]        disp_ones,
    output logic              disp_ovf,
    output logic [NUM_CH-1:0] alarm,
    output logic              stdby_req
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int SW    = DATA_W + 1;
    localparam int VW    = (SW > 7) ? SW : 7;
    localparam int NSMP  = 1 << AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam int SC_W  = $clog2(SETTLE + 2);

    typedef enum logic [2:0] {
        S_SETTLE  = 3'd0,
        S_ACCUM   = 3'd1,
        S_CONVERT = 3'd2,
        S_BCD     = 3'd3,
        S_STORE   = 3'd4
    } state_t;

    // Average -> optional inversion -> two-term shift scale -> offset with
    // clamp at zero -> saturate at 99. Returns {ovf, value[6:0]}.
    function automatic logic [7:0] convert(input logic [ACC_W-1:0] acc);
        logic [DATA_W-1:0] avg;
        logic [DATA_W-1:0] conv;
        logic [SW-1:0]     s;
        logic [VW-1:0]     sx;
        logic [VW-1:0]     v;
        avg  = DATA_W'(acc >> AVG_LOG2);
        conv = (INVERT != 0) ? ~avg : avg;
        s    = SW'(conv >> SHIFT_A) + SW'(conv >> SHIFT_B);
        sx   = VW'(s);
        if (sx < VW'(OFFSET)) v = '0;
        else                  v = sx - VW'(OFFSET);
        if (v > VW'(99)) return {1'b1, 7'd99};
        return {1'b0, v[6:0]};
    endfunction

    state_t               state_q;
    logic [CH_W-1:0]      ch_q;
    logic [SC_W-1:0]      settle_cnt_q;
    logic [SMP_W-1:0]     smp_cnt_q;
    logic [ACC_W-1:0]     acc_q;
    logic [6:0]           rem_q;
    logic [6:0]           vsat_q;
    logic [3:0]           tens_q;
    logic                 ovf_q;
    logic [7:0]           conv_res;

    logic [NUM_CH-1:0][3:0] res_tens_q, res_tens_d;
    logic [NUM_CH-1:0][3:0] res_ones_q, res_ones_d;
    logic [NUM_CH-1:0]      res_ovf_q,  res_ovf_d;
    logic [NUM_CH-1:0]      res_vld_q,  res_vld_d;
    logic [NUM_CH-1:0]      alarm_q,    alarm_d;
    logic                   stdby_q,    stdby_d;

    logic       disp_valid_q, disp_valid_d;
    logic [3:0] disp_tens_q,  disp_tens_d;
    logic [3:0] disp_ones_q,  disp_ones_d;
    logic       disp_ovf_q,   disp_ovf_d;

    assign conv_res = convert(acc_q);

    // Acquisition/conversion sequencer: settle, accumulate, scale, BCD split, store.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_SETTLE;
            ch_q         <= '0;
            settle_cnt_q <= '0;
            smp_cnt_q    <= '0;
            acc_q        <= '0;
            rem_q        <= '0;
            vsat_q       <= '0;
            tens_q       <= '0;
            ovf_q        <= 1'b0;
        end else begin
            case (state_q)
                S_SETTLE: begin
                    if (SETTLE == 0) begin
                        state_q <= S_ACCUM;
                    end else if (sample_rdy) begin
                        if (int'(settle_cnt_q) >= SETTLE - 1) begin
                            settle_cnt_q <= '0;
                            state_q      <= S_ACCUM;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + SC_W'(1);
                        end
                    end
                end
                S_ACCUM: begin
                    if (sample_rdy) begin
                        acc_q <= acc_q + ACC_W'(adc_data);
                        if (int'(smp_cnt_q) == NSMP - 1) begin
                            smp_cnt_q <= '0;
                            state_q   <= S_CONVERT;
                        end else begin
                            smp_cnt_q <= smp_cnt_q + SMP_W'(1);
                        end
                    end
                end
                S_CONVERT: begin
                    ovf_q   <= conv_res[7];
                    rem_q   <= conv_res[6:0];
                    vsat_q  <= conv_res[6:0];
                    tens_q  <= '0;
                    state_q <= S_BCD;
                end
                S_BCD: begin
                    // Repeated subtraction: one tens digit per cycle.
                    if (rem_q >= 7'd10) begin
                        rem_q  <= rem_q - 7'd10;
                        tens_q <= tens_q + 4'd1;
                    end else begin
                        state_q <= S_STORE;
                    end
                end
                S_STORE: begin
                    acc_q   <= '0;
                    ch_q    <= (int'(ch_q) == NUM_CH - 1) ? '0 : ch_q + CH_W'(1);
                    state_q <= (SETTLE == 0) ? S_ACCUM : S_SETTLE;
                end
                default: state_q <= S_SETTLE;
            endcase
        end
    end

    // Next per-channel results and alarms; only a STORE cycle changes them.
    always_comb begin
        res_tens_d = res_tens_q;
        res_ones_d = res_ones_q;
        res_ovf_d  = res_ovf_q;
        res_vld_d  = res_vld_q;
        alarm_d    = alarm_q;
        if (state_q == S_STORE) begin
            res_tens_d[ch_q] = tens_q;
            res_ones_d[ch_q] = rem_q[3:0];
            res_ovf_d[ch_q]  = ovf_q;
            res_vld_d[ch_q]  = 1'b1;
            if (int'(vsat_q) >= ALARM_THR)
                alarm_d[ch_q] = 1'b1;
            else if (int'(vsat_q) < ALARM_THR - ALARM_HYST)
                alarm_d[ch_q] = 1'b0;
        end
        stdby_d = |(alarm_d & ~alarm_q);
    end

    // Hold per-channel results, alarm flags and the standby pulse.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            res_tens_q <= '0;
            res_ones_q <= '0;
            res_ovf_q  <= '0;
            res_vld_q  <= '0;
            alarm_q    <= '0;
            stdby_q    <= 1'b0;
        end else begin
            res_tens_q <= res_tens_d;
            res_ones_q <= res_ones_d;
            res_ovf_q  <= res_ovf_d;
            res_vld_q  <= res_vld_d;
            alarm_q    <= alarm_d;
            stdby_q    <= stdby_d;
        end
    end

    // Display select reads the next-state results so a store and a disp_ch
    // change landing together both show up on the following cycle.
    always_comb begin
        disp_valid_d = 1'b0;
        disp_ovf_d   = 1'b0;
        disp_tens_d  = '0;
        disp_ones_d  = '0;
        if (int'(disp_ch) < NUM_CH) begin
            disp_valid_d = res_vld_d[disp_ch];
            disp_ovf_d   = res_ovf_d[disp_ch];
            disp_tens_d  = res_tens_d[disp_ch];
            disp_ones_d  = res_ones_d[disp_ch];
        end
    end

    // Registered display outputs.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            disp_valid_q <= 1'b0;
            disp_ovf_q   <= 1'b0;
            disp_tens_q  <= '0;
            disp_ones_q  <= '0;
        end else begin
            disp_valid_q <= disp_valid_d;
            disp_ovf_q   <= disp_ovf_d;
            disp_tens_q  <= disp_tens_d;
            disp_ones_q  <= disp_ones_d;
        end
    end

    assign mux_sel    = ch_q;
    assign disp_valid = disp_valid_q;
    assign disp_ovf   = disp_ovf_q;
    assign disp_tens  = disp_tens_q;
    assign disp_ones  = disp_ones_q;
    assign alarm      = alarm_q;
    assign stdby_req  = stdby_q;

endmodule

// File: tb/tb_icc_monitor_seq.sv
// Scoreboard bench for icc_monitor_seq: a stimulus process feeds randomized and
// directed ADC strobes and queues the expected per-conversion results; a
// monitor pops them whenever the DUT advances its mux and checks every cycle.
module tb_icc_monitor_seq;

    localparam int NUM_CH   = 2;
    localparam int NSMP     = 4;
    localparam int SETTLE_N = 1;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       sample_rdy = 1'b0;
    logic [7:0] adc_data = 8'h00;
    logic [0:0] disp_ch = 1'b0;

    logic [0:0] mux_sel;
    logic       disp_valid, disp_ovf, stdby_req;
    logic [3:0] disp_tens, disp_ones;
    logic [1:0] alarm;

    logic [0:0] s_mux;
    logic       s_valid, s_ovf, s_stdby;
    logic [3:0] s_tens, s_ones;
    logic [1:0] s_alarm;

    icc_monitor_seq u_dut (
        .clk_in(clk), .rstn(rstn), .sample_rdy(sample_rdy), .adc_data(adc_data),
        .mux_sel(mux_sel), .disp_ch(disp_ch), .disp_valid(disp_valid),
        .disp_tens(disp_tens), .disp_ones(disp_ones), .disp_ovf(disp_ovf),
        .alarm(alarm), .stdby_req(stdby_req)
    );

    icc_monitor_seq #(.SHIFT_A(1), .SHIFT_B(2)) u_sat (
        .clk_in(clk), .rstn(rstn), .sample_rdy(sample_rdy), .adc_data(adc_data),
        .mux_sel(s_mux), .disp_ch(disp_ch), .disp_valid(s_valid),
        .disp_tens(s_tens), .disp_ones(s_ones), .disp_ovf(s_ovf),
        .alarm(s_alarm), .stdby_req(s_stdby)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [0:0] disp_ch_smp = 1'b0;
    always @(posedge clk) disp_ch_smp <= disp_ch;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, want, cyc);
        end
    endtask

    typedef struct {
        int         ch;
        int         tens;
        int         ones;
        bit         ovf;
        logic [1:0] alarm;
        bit         stdby;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    // ---------------- reference model (stimulus side) ----------------
    int         busy_until, discard_left, m_sum, m_cnt, m_ch, last_p;
    logic [1:0] m_alarm;
    bit         conv_done;

    task automatic model_reset();
        busy_until   = 0;
        discard_left = SETTLE_N;
        m_sum        = 0;
        m_cnt        = 0;
        m_ch         = 0;
        m_alarm      = 2'b00;
    endtask

    // p: clock edge number at which the strobe is sampled
    task automatic model_sample(input int p, input int d);
        exp_t       it;
        int         conv, s, v;
        logic [1:0] prev;
        if (p <= busy_until) return;
        if (discard_left > 0) begin
            discard_left--;
            return;
        end
        m_sum += d;
        m_cnt++;
        if (m_cnt == NSMP) begin
            conv = 255 - (m_sum / NSMP);
            s    = conv / 8 + conv / 16;
            v    = (s < 1) ? 0 : s - 1;
            it.ovf = (v > 99);
            if (v > 99) v = 99;
            prev = m_alarm;
            if (v >= 40)      m_alarm[m_ch] = 1'b1;
            else if (v < 35)  m_alarm[m_ch] = 1'b0;
            it.ch    = m_ch;
            it.tens  = v / 10;
            it.ones  = v % 10;
            it.alarm = m_alarm;
            it.stdby = |(m_alarm & ~prev);
            it.cyc   = p + 3 + v / 10;
            exp_q.push_back(it);
            busy_until   = it.cyc;
            last_p       = p;
            m_ch         = (m_ch + 1) % NUM_CH;
            discard_left = SETTLE_N;
            m_sum        = 0;
            m_cnt        = 0;
            conv_done    = 1'b1;
        end
    endtask

    // ---------------- monitor ----------------
    int         mt[NUM_CH];
    int         mo[NUM_CH];
    bit         mov[NUM_CH];
    bit         mv[NUM_CH];
    logic [1:0] mon_alarm = 2'b00;
    logic [0:0] prev_mux = 1'b0;

    always @(negedge clk) begin : monitor
        exp_t it;
        bit   st;
        int   d, exp_disp, act_disp;
        if (!rstn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mt[i] = 0; mo[i] = 0; mov[i] = 1'b0; mv[i] = 1'b0;
            end
            mon_alarm = 2'b00;
            prev_mux  = 1'b0;
        end else begin
            st = 1'b0;
            if (mux_sel != prev_mux) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_store", 1, 0);
                end else begin
                    it = exp_q.pop_front();
                    chk("store_cycle", cyc, it.cyc);
                    chk("store_ch", int'(prev_mux), it.ch);
                    mt[it.ch] = it.tens; mo[it.ch] = it.ones;
                    mov[it.ch] = it.ovf; mv[it.ch] = 1'b1;
                    mon_alarm = it.alarm;
                    st = it.stdby;
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
                it = exp_q.pop_front();
                chk("store_missing", cyc, it.cyc);
                mt[it.ch] = it.tens; mo[it.ch] = it.ones;
                mov[it.ch] = it.ovf; mv[it.ch] = 1'b1;
                mon_alarm = it.alarm;
            end
            prev_mux = mux_sel;
            chk("alarm", int'(alarm), int'(mon_alarm));
            chk("stdby_req", int'(stdby_req), int'(st));
            d        = int'(disp_ch_smp);
            exp_disp = (mv[d] ? 512 : 0) + (mov[d] ? 256 : 0) + mt[d] * 16 + mo[d];
            act_disp = int'({disp_valid, disp_ovf, disp_tens, disp_ones});
            chk("display", act_disp, exp_disp);
        end
    end

    // ---------------- stimulus ----------------
    int         disp_mode = 1;   // 0 hold, 1 random, 2 toggle every cycle
    logic [0:0] disp_hold = 1'b0;

    task automatic cycle(input bit s, input logic [7:0] d);
        sample_rdy = s;
        adc_data   = s ? d : 8'($urandom);
        case (disp_mode)
            0:       disp_ch = disp_hold;
            1:       disp_ch = 1'($urandom);
            default: disp_ch = ~disp_ch;
        endcase
        if (s) model_sample(cyc + 1, int'(d));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cyc <= busy_until + 1) && n < 300) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic run_conv(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] e);
        cycle(1'b1, 8'hA5);   // dropped after the mux switch
        cycle(1'b1, a);
        cycle(1'b1, b);
        cycle(1'b1, c);
        cycle(1'b1, e);
        drain();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [7:0] base;
        model_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mux", int'(mux_sel), 0);
        chk("rst_display", int'({disp_valid, disp_ovf, disp_tens, disp_ones}), 0);
        chk("rst_alarm", int'({alarm, stdby_req}), 0);
        rstn = 1'b1;

        // Directed: plain average, split average, clamp to 0, alarm hysteresis
        disp_mode = 0; disp_hold = 1'b0;
        run_conv(8'h7F, 8'h7F, 8'h7F, 8'h7F);        // ch0 -> 23
        disp_mode = 1;
        run_conv(8'hFF, 8'hFF, 8'hFF, 8'hFF);        // ch1 -> 0
        run_conv(8'h00, 8'h00, 8'hFF, 8'hFF);        // ch0 -> 23
        run_conv(8'h7F, 8'h7F, 8'h7F, 8'h7F);        // ch1 -> 23
        run_conv(8'h00, 8'h00, 8'h00, 8'h00);        // ch0 -> 45, alarm rise
        disp_mode = 2;
        run_conv(8'h00, 8'h00, 8'h00, 8'h00);        // ch1 -> 45, alarm rise
        run_conv(8'h3F, 8'h3F, 8'h3F, 8'h3F);        // ch0 -> 35, hold
        run_conv(8'h4F, 8'h4F, 8'h4F, 8'h4F);        // ch1 -> 32, clear
        run_conv(8'h4F, 8'h4F, 8'h4F, 8'h4F);        // ch0 -> 32, clear

        // Randomized strobe stream, including strobes during busy windows
        base = 8'h7F;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0)   disp_mode = 1;
            if (i % 500 == 250) disp_mode = 2;
            conv_done = 1'b0;
            cycle($urandom_range(0, 99) < 60, base ^ 8'($urandom_range(0, 3)));
            if (conv_done) begin
                case ($urandom_range(0, 5))
                    0:       base = 8'h00;
                    1:       base = 8'h3F;
                    2:       base = 8'h4F;
                    3:       base = 8'h7F;
                    4:       base = 8'hFF;
                    default: base = 8'($urandom);
                endcase
            end
        end
        drain();

        // Reset while the BCD split is running aborts the conversion
        disp_mode = 1;
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h00);
        cycle(1'b1, 8'hFF);
        cycle(1'b1, 8'hFF);
        rstn = 1'b0;
        chk("abort_pending", exp_q.size(), 1);
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        #1;
        chk("abort_mux", int'(mux_sel), 0);
        chk("abort_display", int'({disp_valid, disp_ovf, disp_tens, disp_ones}), 0);
        chk("abort_alarm", int'({alarm, stdby_req}), 0);
        @(posedge clk);
        #1;
        model_reset();
        rstn = 1'b1;

        // Fresh start lands on ch0; saturating instance reaches 99 with ovf
        disp_mode = 0; disp_hold = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h00);
        while (cyc < last_p + 11) cycle(1'b0, 8'h00);
        chk("sat_mux_before", int'(s_mux), 0);
        cycle(1'b0, 8'h00);
        chk("sat_mux_after", int'(s_mux), 1);
        chk("sat_display", int'({s_valid, s_ovf, s_tens, s_ones}), 10'h399);
        chk("sat_alarm", int'(s_alarm), 1);
        chk("sat_stdby", int'(s_stdby), 1);
        cycle(1'b0, 8'h00);
        chk("sat_stdby_pulse_end", int'(s_stdby), 0);
        drain();

        sample_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
